// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the mips_mdu multiply/divide unit: op encodings,
// FSM state type and the default datapath width.
package mips_mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_mdu_step.sv
// One radix-2 iteration of the MDU engine: shift-add multiply step, or a
// restoring-divide step when MIPS_MDU_DIV_EN is defined.
module mips_mdu_step
  import mips_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
`ifdef MIPS_MDU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lsr_i,
  input  logic [WIDTH-1:0] opd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lsr_o
);

  logic [WIDTH:0] sum;
`ifdef MIPS_MDU_DIV_EN
  logic [WIDTH:0] rem;
  logic [WIDTH:0] trial;
`endif

  always_comb begin
    // {acc, lsr} acts as one 2*WIDTH shift register; the multiplier drains
    // out of lsr while product bits fill in from the top.
    sum   = {1'b0, acc_i} + (lsr_i[0] ? {1'b0, opd_i} : '0);
    acc_o = sum[WIDTH:1];
    lsr_o = {sum[0], lsr_i[WIDTH-1:1]};
`ifdef MIPS_MDU_DIV_EN
    rem   = {acc_i, lsr_i[WIDTH-1]};
    trial = rem - {1'b0, opd_i};
    if (div_i) begin
      // Partial remainder stays below the divisor, so bit WIDTH of the
      // trial difference is a reliable borrow.
      if (!trial[WIDTH]) begin
        acc_o = trial[WIDTH-1:0];
        lsr_o = {lsr_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem[WIDTH-1:0];
        lsr_o = {lsr_i[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/mips_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. The divider is compiled
// only when MIPS_MDU_DIV_EN is defined; otherwise DIV/DIVU complete at once.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  mdu_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, lsr_q, opd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, neg_q;
`ifdef MIPS_MDU_DIV_EN
  logic [WIDTH-1:0] a_q;
  logic             div_q, rneg_q, bzero_q, div0_q;
`endif

  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_acc, step_lsr;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fix_hi_d, fix_lo_d;

  always_comb begin
    is_signed = op_is_signed(op);
    a_neg     = is_signed & op_a[WIDTH-1];
    b_neg     = is_signed & op_b[WIDTH-1];
    a_abs     = a_neg ? -op_a : op_a;
    b_abs     = b_neg ? -op_b : op_b;
  end

  mips_mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MIPS_MDU_DIV_EN
    .div_i (div_q),
`endif
    .acc_i (acc_q),
    .lsr_i (lsr_q),
    .opd_i (opd_q),
    .acc_o (step_acc),
    .lsr_o (step_lsr)
  );

  always_comb begin
    prod = {acc_q, lsr_q};
    if (neg_q) prod = -prod;
    fix_hi_d = prod[2*WIDTH-1:WIDTH];
    fix_lo_d = prod[WIDTH-1:0];
`ifdef MIPS_MDU_DIV_EN
    // Quotient takes the XOR sign, remainder follows the dividend.
    if (div_q) begin
      fix_lo_d = neg_q  ? -lsr_q : lsr_q;
      fix_hi_d = rneg_q ? -acc_q : acc_q;
      if (bzero_q) begin
        fix_lo_d = '1;
        fix_hi_d = a_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lsr_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
`ifdef MIPS_MDU_DIV_EN
      a_q     <= '0;
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (mthi) hi_q <= op_a;
          if (mtlo) lo_q <= op_a;
          if (!start) begin
            state_q <= IDLE;
`ifndef MIPS_MDU_DIV_EN
          end else if (op_is_div(op)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            lsr_q   <= a_abs;
            opd_q   <= b_abs;
            neg_q   <= a_neg ^ b_neg;
`ifdef MIPS_MDU_DIV_EN
            a_q     <= op_a;
            div_q   <= op_is_div(op);
            rneg_q  <= a_neg;
            bzero_q <= (op_b == '0);
`endif
          end
        end
        CALC: begin
          acc_q <= step_acc;
          lsr_q <= step_lsr;
          cnt_q <= cnt_q + 1'b1;
          if (32'(cnt_q) == WIDTH - 1) state_q <= FIXUP;
        end
        FIXUP: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
`ifdef MIPS_MDU_DIV_EN
          if (div_q) div0_q <= bzero_q;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MIPS_MDU_DIV_EN
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

endmodule
